// File: rtl/timera_count_ctrl_if.sv
// timera_count_ctrl_if: peripheral bus strobes and write data toward the Timer_A control block
interface timera_count_ctrl_if #(
  parameter int WIDTH = 16
);
  logic             wTACTL;
  logic             wTAEX0;
  logic             wTAR;
  logic             rTAIV;
  logic [WIDTH-1:0] DataIn;
  modport master (output wTACTL, wTAEX0, wTAR, rTAIV, DataIn);
  modport slave  (input  wTACTL, wTAEX0, wTAR, rTAIV, DataIn);
endinterface

// File: rtl/timera_count_ctrl.sv
// timera_count_ctrl: Timer_A control registers, TimerClock tick synchroniser and TAR sequencer
module timera_count_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic               MCLK,
  input  logic               reset,
  input  logic               TimerClock,
  timera_count_ctrl_if.slave bus,
  input  logic [WIDTH-1:0]   TACCR0,
  output logic [1:0]         TASSEL,
  output logic [1:0]         ID,
  output logic [2:0]         IDEX,
  output logic [1:0]         MC,
  output logic               wTACLR,
  output logic [WIDTH-1:0]   TACTL,
  output logic [WIDTH-1:0]   TAR,
  output logic               DIR,
  output logic               EQU0,
  output logic               TAIFG,
  output logic               TAIRQ
);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  logic [2:0]       tclk_q;
  logic             tick;
  logic             taie;
  logic             clr;
  logic             hw_set;
  logic             roll;
  logic             dir_nx;
  logic [WIDTH-1:0] tar_nx;
  assign tick   = tclk_q[1] & ~tclk_q[2];
  assign clr    = bus.wTACTL & bus.DataIn[2];
  assign hw_set = tick & roll & ~clr & ~bus.wTAR;
  assign EQU0   = TAR == TACCR0;
  assign TAIRQ  = TAIFG & taie;
  assign TACTL  = {{(WIDTH-10){1'b0}}, TASSEL, ID, MC, 2'b00, taie, TAIFG};
  // two-flop synchroniser plus one history flop for the rising-edge detector
  always_ff @(posedge MCLK or negedge reset)
    if (!reset) tclk_q <= '0;
    else tclk_q <= {tclk_q[1:0], TimerClock};
  // configuration registers and the one-cycle pre-divider clear pulse
  always_ff @(posedge MCLK or negedge reset)
    if (!reset) begin
      {TASSEL, ID, MC} <= '0;
      taie             <= 1'b0;
      IDEX             <= '0;
      wTACLR           <= 1'b0;
    end else begin
      wTACLR <= clr;
      if (bus.wTACTL) {TASSEL, ID, MC} <= bus.DataIn[9:4];
      if (bus.wTACTL) taie <= bus.DataIn[1];
      if (bus.wTAEX0) IDEX <= bus.DataIn[2:0];
    end
  // counter step for one tick in the current mode, with rollover detection
  always_comb begin
    tar_nx = TAR;
    dir_nx = DIR;
    roll   = 1'b0;
    if (MC == 2'b01) begin
      tar_nx = (TAR < TACCR0) ? TAR + ONE : '0;
      roll   = (TAR == TACCR0) && (TACCR0 != '0);
    end else if (MC == 2'b10) begin
      tar_nx = TAR + ONE;
      roll   = &TAR;
    end else if (MC == 2'b11 && TACCR0 != '0) begin
      if (!DIR) begin
        dir_nx = TAR >= TACCR0;
        tar_nx = dir_nx ? TAR - ONE : TAR + ONE;
      end else if (TAR == '0) begin
        dir_nx = 1'b0;
        tar_nx = ONE;
      end else if (TAR == ONE) begin
        dir_nx = 1'b0;
        tar_nx = '0;
        roll   = 1'b1;
      end else begin
        tar_nx = TAR - ONE;
      end
    end
  end
  // TAR/DIR/TAIFG update: clear beats bus write beats tick; leaving up/down forces DIR low
  always_ff @(posedge MCLK or negedge reset)
    if (!reset) begin
      TAR   <= '0;
      DIR   <= 1'b0;
      TAIFG <= 1'b0;
    end else begin
      TAR   <= clr ? '0 : bus.wTAR ? bus.DataIn : tick ? tar_nx : TAR;
      DIR   <= (clr || (bus.wTACTL && bus.DataIn[5:4] != 2'b11)) ? 1'b0 :
               (bus.wTAR || !tick) ? DIR : dir_nx;
      TAIFG <= hw_set | (bus.wTACTL ? bus.DataIn[0] : TAIFG & ~bus.rTAIV);
    end
endmodule

// File: tb/tb_timera_count_ctrl.sv
// tb_timera_count_ctrl: randomized scoreboard bench for the Timer_A count sequencer
module tb_timera_count_ctrl;
  localparam int W = 16;
  logic          MCLK = 1'b0;
  logic          reset = 1'b0;
  logic          TimerClock = 1'b0;
  logic [W-1:0]  TACCR0 = '0;
  logic [1:0]    TASSEL, ID, MC;
  logic [2:0]    IDEX;
  logic          wTACLR, DIR, EQU0, TAIFG, TAIRQ;
  logic [W-1:0]  TACTL, TAR;

  timera_count_ctrl_if #(.WIDTH(W)) bus ();

  timera_count_ctrl #(.WIDTH(W)) dut (
    .MCLK(MCLK), .reset(reset), .TimerClock(TimerClock), .bus(bus.slave),
    .TACCR0(TACCR0), .TASSEL(TASSEL), .ID(ID), .IDEX(IDEX), .MC(MC),
    .wTACLR(wTACLR), .TACTL(TACTL), .TAR(TAR), .DIR(DIR), .EQU0(EQU0),
    .TAIFG(TAIFG), .TAIRQ(TAIRQ)
  );

  always #5 MCLK = ~MCLK;

  typedef struct {
    int       tar;
    bit       dir, ifg, ie, clrp;
    bit [1:0] mc, ssel, id;
    bit [2:0] idex;
  } exp_t;

  exp_t     q[$];
  exp_t     m;
  bit [2:0] hist;
  int       passed = 0;
  int       total = 0;
  int       tc_cnt = 0;
  bit       rnd_tc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // monitor: every MCLK cycle the DUT presents a fresh state; compare it with the oldest prediction
  always @(negedge MCLK) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("TAR", TAR, e.tar);
      chk("DIR", DIR, e.dir);
      chk("TAIFG", TAIFG, e.ifg);
      chk("TAIRQ", TAIRQ, e.ifg & e.ie);
      chk("TACTL", TACTL, {6'b0, e.ssel, e.id, e.mc, 2'b00, e.ie, e.ifg});
      chk("wTACLR", wTACLR, e.clrp);
      chk("IDEX", IDEX, e.idex);
      chk("EQU0", EQU0, e.tar == int'(TACCR0));
    end
  end

  // reference model: one MCLK edge, tick derived from TimerClock two edges back
  task automatic step();
    bit tick = hist[1] & ~hist[2];
    bit clr = bus.wTACTL & bus.DataIn[2];
    int ccr = int'(TACCR0);
    int nt = m.tar;
    bit nd = m.dir;
    bit hw = 0;
    hist = {hist[1:0], TimerClock};
    if (tick) begin
      if (m.mc == 1) begin
        if (m.tar < ccr) nt = m.tar + 1;
        else begin
          nt = 0;
          hw = (m.tar == ccr) && (ccr != 0);
        end
      end else if (m.mc == 2) begin
        nt = (m.tar + 1) % 65536;
        hw = (nt == 0);
      end else if (m.mc == 3 && ccr != 0) begin
        if (!m.dir) begin
          if (m.tar < ccr) nt = m.tar + 1;
          else begin nd = 1; nt = m.tar - 1; end
        end else if (m.tar > 1) nt = m.tar - 1;
        else if (m.tar == 1) begin nt = 0; nd = 0; hw = 1; end
        else begin nt = 1; nd = 0; end
      end
    end
    if (clr) begin nt = 0; nd = 0; hw = 0; end
    else if (bus.wTAR) begin nt = int'(bus.DataIn); nd = m.dir; hw = 0; end
    if (bus.wTACTL && bus.DataIn[5:4] != 2'b11) nd = 0;
    m.ifg = hw ? 1'b1 : bus.wTACTL ? bus.DataIn[0] : bus.rTAIV ? 1'b0 : m.ifg;
    if (bus.wTACTL) begin
      m.ssel = bus.DataIn[9:8];
      m.id   = bus.DataIn[7:6];
      m.mc   = bus.DataIn[5:4];
      m.ie   = bus.DataIn[1];
    end
    if (bus.wTAEX0) m.idex = bus.DataIn[2:0];
    m.clrp = clr;
    m.tar  = nt;
    m.dir  = nd;
    q.push_back(m);
  endtask

  task automatic cyc(input bit ctl, input bit ex, input bit wt, input bit iv, input logic [15:0] d);
    bus.wTACTL = ctl;
    bus.wTAEX0 = ex;
    bus.wTAR   = wt;
    bus.rTAIV  = iv;
    bus.DataIn = d;
    if (tc_cnt == 0) begin
      TimerClock = ~TimerClock;
      tc_cnt = rnd_tc ? int'($urandom_range(2, 4)) : 2;
    end
    tc_cnt--;
    @(posedge MCLK);
    step();
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 16'h0);
  endtask

  task automatic wait_tick();
    int n = 0;
    while (!(hist[1] & ~hist[2]) && n < 50) begin idle(1); n++; end
    if (n == 50) chk("tick_wait", 0, 1);
  endtask

  task automatic rst_check();
    chk("rst_TAR", TAR, 0);
    chk("rst_DIR", DIR, 0);
    chk("rst_TAIFG", TAIFG, 0);
    chk("rst_TAIRQ", TAIRQ, 0);
    chk("rst_TACTL", TACTL, 0);
    chk("rst_wTACLR", wTACLR, 0);
    chk("rst_IDEX", IDEX, 0);
    chk("rst_EQU0", EQU0, TACCR0 == '0);
  endtask

  task automatic async_reset();
    @(negedge MCLK);
    #1 reset = 1'b0;
    #1 rst_check();
    m = '{default: 0};
    hist = '0;
    #1 reset = 1'b1;
  endtask

  initial begin
    int n;
    int r;
    logic [15:0] d;
    bus.wTACTL = 0; bus.wTAEX0 = 0; bus.wTAR = 0; bus.rTAIV = 0; bus.DataIn = '0;
    m = '{default: 0};
    hist = '0;
    #2 rst_check();
    #1 reset = 1'b1;
    idle(3);
    // up mode, period 4, flag cleared by a TAIV read
    TACCR0 = 16'd4;
    cyc(1, 0, 0, 0, 16'h0010);
    idle(30);
    cyc(0, 0, 0, 1, 16'h0);
    idle(4);
    // continuous wrap with and without interrupt enable, plus a TAxEX0 write
    cyc(1, 0, 0, 0, 16'h0000);
    cyc(0, 1, 0, 0, 16'h0005);
    cyc(0, 0, 1, 0, 16'hFFFE);
    cyc(1, 0, 0, 0, 16'h02E2);
    idle(12);
    cyc(1, 0, 0, 0, 16'h0000);
    cyc(0, 0, 1, 0, 16'hFFFE);
    cyc(1, 0, 0, 0, 16'h0020);
    idle(12);
    // up/down with period 3, started through a clearing write
    TACCR0 = 16'd3;
    cyc(1, 0, 0, 0, 16'h0034);
    idle(40);
    // TACLR landing on a tick while counting up
    TACCR0 = 16'h10;
    cyc(1, 0, 0, 0, 16'h0010);
    wait_tick();
    idle(1);
    cyc(0, 0, 1, 0, 16'd7);
    idle(2);
    cyc(1, 0, 0, 0, 16'h0014);
    idle(3);
    // bus write of TAR coinciding with a tick
    wait_tick();
    cyc(0, 0, 1, 0, 16'h0055);
    idle(2);
    // hardware flag set coinciding with a TAIV read
    TACCR0 = 16'd2;
    cyc(1, 0, 0, 0, 16'h0012);
    n = 0;
    while (!((hist[1] & ~hist[2]) && m.tar == 2) && n < 100) begin idle(1); n++; end
    if (n == 100) chk("rollover_wait", 0, 1);
    cyc(0, 0, 0, 1, 16'h0);
    idle(3);
    // asynchronous reset mid-count; counting resumes only after MC is rewritten
    idle(5);
    async_reset();
    idle(20);
    cyc(1, 0, 0, 0, 16'h0020);
    idle(10);
    // randomized traffic
    rnd_tc = 1;
    for (int i = 0; i < 2500; i++) begin
      r = int'($urandom_range(0, 99));
      d = 16'($urandom);
      if (r < 2) TACCR0 = 16'($urandom_range(0, 8));
      if (r >= 4 && r < 8) begin
        if ($urandom_range(0, 3) != 0) d[2] = 1'b0;
        cyc(1, 0, 0, 0, d);
      end else if (r >= 8 && r < 10) cyc(0, 1, 0, 0, d);
      else if (r >= 10 && r < 13) begin
        if (r == 10) d = 16'($urandom_range(16'hFFFA, 16'hFFFF));
        else if (r == 11) d = 16'($urandom_range(0, 9));
        cyc(0, 0, 1, 0, d);
      end else if (r >= 13 && r < 18) cyc(0, 0, 0, 1, d);
      else cyc(0, 0, 0, 0, d);
    end
    @(negedge MCLK);
    #1 chk("drain", q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/timera_count_ctrl.md
# timera_count_ctrl

Control and count sequencer for Timer_A. The block holds the TAxCTL and TAxEX0 configuration registers and drives the select, divide and clear controls of the Timer_A clock pre-divider. It synchronises the pre-divider's `TimerClock` output into the MCLK domain and uses each timer tick to step the 16-bit TAR counter in stop, up, continuous or up/down mode. It raises TAIFG on the mode-specific rollover and sits between the peripheral bus decode and the capture/compare channels, which consume `TAR`, `EQU0` and `DIR`.

## Interface
- `WIDTH`, 16, width of TAR, TACCR0 and the data bus

- `MCLK` in 1: system clock; all state is in this domain
- `reset` in 1: asynchronous, active-low; clears all state
- `TimerClock` in 1: divided timer clock from the pre-divider; asynchronous to MCLK
- `wTACTL` in 1: write strobe for TAxCTL
- `wTAEX0` in 1: write strobe for TAxEX0
- `wTAR` in 1: write strobe for TAR
- `rTAIV` in 1: TAIV read; clears TAIFG
- `DataIn` in WIDTH: bus write data
- `TACCR0` in WIDTH: period register from CCR channel 0
- `TASSEL` out 2: TAxCTL[9:8], to the pre-divider
- `ID` out 2: TAxCTL[7:6], to the pre-divider
- `IDEX` out 3: TAxEX0[2:0], to the pre-divider
- `MC` out 2: TAxCTL[5:4], mode control
- `wTACLR` out 1: one-cycle clear pulse to the pre-divider
- `TACTL` out WIDTH: read-back value {6'b0, TASSEL, ID, MC, 1'b0, 1'b0, TAIE, TAIFG}; TACLR always reads 0
- `TAR` out WIDTH: counter value
- `DIR` out 1: 0 = counting up, 1 = counting down
- `EQU0` out 1: combinational, TAR == TACCR0
- `TAIFG` out 1: timer overflow flag
- `TAIRQ` out 1: TAIFG & TAIE

## Operation
- **Register write (TAxCTL):** `wTACTL` loads TASSEL, ID, MC, TAIE and TAIFG from `DataIn[9:4]`, `[1]` and `[0]`.
- **Clear bit:** `DataIn[2]` (TACLR) is self-clearing and is never stored.
- **Register write (TAxEX0):** `wTAEX0` loads IDEX from `DataIn[2:0]`.
- **Tick generation:**
  - 2-flop synchroniser on `TimerClock`, followed by a rising-edge detector.
  - The detector produces `tick`, one MCLK cycle wide.
- **Stop mode (MC=00):** ticks are ignored and TAR holds.
- **Up mode (MC=01):**
  - On a tick, if TAR < TACCR0 then TAR+1.
  - If TAR == TACCR0 then TAR←0 and TAIFG←1.
  - If TAR > TACCR0 then TAR←0 with no TAIFG.
  - If TACCR0 == 0 then TAR holds at 0 with no TAIFG.
- **Continuous mode (MC=10):** TAR+1 modulo 2^WIDTH; TAIFG←1 on the 0xFFFF→0 transition.
- **Up/down mode (MC=11):**
  - With DIR=0: if TAR < TACCR0 then TAR+1; otherwise DIR←1 and TAR−1.
  - With DIR=1: if TAR > 1 then TAR−1; at TAR == 1, TAR←0, DIR←0 and TAIFG←1.
  - If TAR == 0 while DIR=1, then DIR←0 and TAR+1.
  - If TACCR0 == 0, TAR holds.
- **TACLR (write with `DataIn[2]`=1):**
  - TAR←0 and DIR←0.
  - `wTACLR` pulses in the following cycle, which resets the pre-divider count.
  - The other TAxCTL fields load normally in the same write.
- **Priority per MCLK edge for TAR/DIR:** reset > TACLR > `wTAR` (TAR←DataIn, DIR unchanged) > tick.
- **Priority for TAIFG:** reset > hardware set > `wTACTL` bit 0 write > `rTAIV` clear. A set and a clear in the same cycle leave TAIFG=1.
- **Mode change:** MC changes take effect on the next tick. DIR is preserved, except that a change into MC=11 leaves DIR as-is and a change out of MC=11 forces DIR←0.

## Timing
- **Reset values:** every output and internal register is 0, including TASSEL, ID, IDEX, MC, TAR, DIR, TAIFG, TAIE, `wTACLR` and the synchroniser flops. `EQU0` therefore resets to (TACCR0 == 0).
- **TimerClock to TAR latency:** TAR updates on the 3rd MCLK rising edge after the `TimerClock` rising edge (2 edges for synchronisation, 1 for the update).
- **TimerClock requirement:** high and low phases each ≥ 2 MCLK periods.
- **Write timing:**
  - Register writes take effect at the MCLK edge on which the strobe is sampled; outputs change after that edge.
  - `wTACLR` is high for exactly one cycle, on the edge after the TACLR write.
- **TAIFG timing:** TAIFG and `TAIRQ` assert on the same edge as the TAR rollover.
- **Reset mid-count:** asynchronous reset takes effect immediately. Counting resumes only after a non-zero MC is written.

## Test plan
- **Up mode rollover:** TACCR0=4, MC=01, TimerClock = MCLK/4 → TAR sequence 0,1,2,3,4,0,1…; TAIFG set on the 4→0 edge; `rTAIV` clears it.
- **Continuous wrap:** `wTAR` with 0xFFFE, then MC=10 → TAR goes 0xFFFF, then 0x0000 with TAIFG=1; `TAIRQ`=1 only when TAIE=1.
- **Up/down:** TACCR0=3, MC=11 → TAR goes 0,1,2,3,2,1,0,1…; DIR=1 during 2,1; TAIFG set on the 1→0 step only.
- **TACLR mid-count:** TACCR0=0x10, TAR=7, TACTL write with bit2=1 coincident with a tick → TAR=0, DIR=0; `wTACLR` high for one cycle; TACTL reads bit2=0.
- **Flag and priority collisions:**
  - Hardware TAIFG set in the same cycle as `rTAIV` → TAIFG=1.
  - `wTAR`=0x55 in the same cycle as a tick → TAR=0x55.
- **Async reset mid-count:** assert reset mid-count → all outputs 0 immediately; no ticks are counted until MC is rewritten.
